// File: rtl/vpu_pkg.sv
// Shared definitions for the VPU scheduler: instruction layout, opcodes
// and the scheduler state encoding.
package vpu_pkg;

  typedef struct packed {
    logic [7:0] rsvd;
    logic [4:0] cnst;
    logic [4:0] c;
    logic [4:0] b;
    logic [4:0] a;
    logic [3:0] opcode;
  } inst_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HALTED,
    ST_ERR
  } sched_state_t;

  function automatic logic isHalt(input inst_t inst);
    return inst.opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/vpu_inst_fifo.sv
// Instruction FIFO for the VPU scheduler; full/empty come from an extra
// wrap bit on each pointer.
module vpu_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_data  = r_mem[r_rdPtr[AW-1:0]];

  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign w_doPush = i_push && !i_flush && (!o_full || i_pop);
  assign w_doPop  = i_pop && !i_flush && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/vpu_sched.sv
// VPU instruction scheduler: queues host instructions and issues them one
// at a time to the VPU, with HALT/resume, flush and a completion watchdog.
module vpu_sched
  import vpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_inst,
  output logic             in_ready,
  output logic [31:0]      vpu_inst,
  output logic             vpu_start,
  output logic             vpu_read_en,
  output logic             vpu_write_en,
  input  logic             vpu_done,
  input  logic             resume,
  input  logic             flush,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  sched_state_t     r_state;
  inst_t            r_inst;
  logic [CNT_W-1:0] r_retired;
  logic [WD_W-1:0]  r_wdog;
  logic             r_err;
  logic             r_start;
  logic             r_enable;
  logic             r_busy;
  logic             r_halted;

  inst_t w_head;
  logic  w_full;
  logic  w_empty;
  logic  w_push;
  logic  w_pop;

  assign in_ready = !w_full && (r_state != ST_ERR);
  assign w_push   = in_valid && in_ready;
  // A flush in IDLE wins over the pop so nothing stale reaches the VPU.
  assign w_pop    = (r_state == ST_IDLE) && !w_empty && !flush;

  vpu_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_data  (in_inst),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_inst    <= '0;
      r_retired <= '0;
      r_wdog    <= '0;
      r_err     <= 1'b0;
      r_start   <= 1'b0;
      r_enable  <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            if (isHalt(w_head)) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_inst   <= w_head;
              r_state  <= ST_ISSUE;
              r_start  <= 1'b1;
              r_enable <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
          r_wdog  <= '0;
        end
        // Completion takes priority over a watchdog expiry in the same cycle.
        ST_WAIT: begin
          if (vpu_done) begin
            r_retired <= r_retired + CNT_W'(1);
            r_state   <= ST_IDLE;
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_wdog == WD_LAST) begin
            r_err    <= 1'b1;
            r_state  <= ST_ERR;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        ST_HALTED: begin
          if (resume || flush) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign vpu_inst     = r_inst;
  assign vpu_start    = r_start;
  assign vpu_read_en  = r_enable;
  assign vpu_write_en = r_enable;
  assign busy         = r_busy;
  assign halted       = r_halted;
  assign err          = r_err;
  assign retired      = r_retired;

endmodule

// File: tb/tb_vpu_sched.sv
// Self-checking bench for vpu_sched: a queue-based scheduler model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_vpu_sched;
  import vpu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [31:0]      in_inst;
  logic             in_ready;
  logic [31:0]      vpu_inst;
  logic             vpu_start;
  logic             vpu_read_en;
  logic             vpu_write_en;
  logic             vpu_done;
  logic             resume;
  logic             flush;
  logic             busy;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] retired;

  logic respDone;
  logic strayDone;
  assign vpu_done = respDone | strayDone;

  always #5 clk = ~clk;

  vpu_sched #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_inst      (in_inst),
    .in_ready     (in_ready),
    .vpu_inst     (vpu_inst),
    .vpu_start    (vpu_start),
    .vpu_read_en  (vpu_read_en),
    .vpu_write_en (vpu_write_en),
    .vpu_done     (vpu_done),
    .resume       (resume),
    .flush        (flush),
    .busy         (busy),
    .halted       (halted),
    .err          (err),
    .retired      (retired)
  );

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Scheduler model: phase per the state rules, FIFO contents as a queue.
  typedef enum {M_IDLE, M_ISSUE, M_WAIT, M_HALTED, M_ERR} mphase_t;
  logic [31:0]      mQueue[$];
  mphase_t          mPhase   = M_IDLE;
  logic [31:0]      mInst    = '0;
  int               mWaitCyc = 0;
  logic [CNT_W-1:0] mRetired = '0;
  bit               mErr     = 1'b0;
  bit               mReady   = 1'b1;
  bit               mPushOk;
  logic [31:0]      mHead;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      mQueue.delete();
      mPhase = M_IDLE; mInst = '0; mWaitCyc = 0;
      mRetired = '0; mErr = 1'b0; mReady = 1'b1;
    end else begin
      mPushOk = in_valid && mReady && !flush;
      case (mPhase)
        M_IDLE:
          if (!flush && mQueue.size() != 0) begin
            mHead = mQueue.pop_front();
            if (mHead[3:0] == OP_HALT) mPhase = M_HALTED;
            else begin mInst = mHead; mPhase = M_ISSUE; end
          end
        M_ISSUE: begin mPhase = M_WAIT; mWaitCyc = 0; end
        M_WAIT:
          if (vpu_done) begin mRetired = mRetired + 1'b1; mPhase = M_IDLE; end
          else begin
            mWaitCyc++;
            if (mWaitCyc == TIMEOUT) begin mErr = 1'b1; mPhase = M_ERR; end
          end
        M_HALTED: if (resume || flush) mPhase = M_IDLE;
        default: ;
      endcase
      if (flush) mQueue.delete();
      if (mPushOk) mQueue.push_back(in_inst);
      mReady = (mQueue.size() < DEPTH) && (mPhase != M_ERR);
    end
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      checkOutput("in_ready", in_ready, mReady);
      checkOutput("vpu_start", vpu_start, mPhase == M_ISSUE);
      checkOutput("vpu_read_en", vpu_read_en, mPhase inside {M_ISSUE, M_WAIT});
      checkOutput("vpu_write_en", vpu_write_en, mPhase inside {M_ISSUE, M_WAIT});
      checkOutput("busy", busy, mPhase inside {M_ISSUE, M_WAIT});
      checkOutput("halted", halted, mPhase == M_HALTED);
      checkOutput("err", err, mErr);
      checkOutput("retired", retired, mRetired);
      if (mPhase inside {M_ISSUE, M_WAIT}) checkOutput("vpu_inst", vpu_inst, mInst);
    end
  end

  // VPU stand-in: pulses vpu_done doneDelay cycles after each start.
  bit vpuAuto   = 1'b0;
  int doneDelay = 3;
  int respCnt   = 0;
  initial begin
    respDone = 1'b0;
    forever begin
      @(posedge clk); #1;
      respDone = 1'b0;
      if (!rst_n) respCnt = 0;
      else begin
        if (respCnt > 0) begin
          respCnt--;
          if (respCnt == 0) respDone = 1'b1;
        end
        if (vpu_start && vpuAuto) respCnt = doneDelay;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic [31:0] inst);
    int budget = 0;
    bit taken  = 1'b0;
    in_valid = 1'b1;
    in_inst  = inst;
    while (!taken && budget < 40) begin
      @(posedge clk);
      taken = in_ready;
      budget++;
    end
    #1 in_valid = 1'b0;
    if (!taken) reportTimeout("push accepted");
  endtask

  task automatic waitRetired(input logic [CNT_W-1:0] target, input string name);
    int n = 0;
    while (retired !== target && n < 100) begin step(1); n++; end
    if (retired !== target) reportTimeout(name);
  endtask

  task automatic waitStart(input string name);
    int n = 0;
    while (vpu_start !== 1'b1 && n < 40) begin step(1); n++; end
    if (vpu_start !== 1'b1) reportTimeout(name);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " in_ready"}, in_ready, 1'b1);
    checkOutput({tag, " vpu_start"}, vpu_start, 1'b0);
    checkOutput({tag, " enables"}, {vpu_read_en, vpu_write_en}, 2'b00);
    checkOutput({tag, " busy"}, busy, 1'b0);
    checkOutput({tag, " halted"}, halted, 1'b0);
    checkOutput({tag, " err"}, err, 1'b0);
    checkOutput({tag, " retired"}, retired, 16'd0);
    checkOutput({tag, " vpu_inst"}, vpu_inst, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0;
    resume = 1'b0; flush = 1'b0; strayDone = 1'b0;
    step(2);
    checking = 1'b1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    step(1);

    $display("[TB] back-to-back issue of three instructions");
    vpuAuto = 1'b1; doneDelay = 3;
    applyStimulus(32'hA512_3451);
    applyStimulus(32'h3C00_1232);
    applyStimulus(32'hFF0F_FFF3);
    waitRetired(16'd3, "three retired");
    checkOutput("model retired 3", mRetired, 16'd3);

    $display("[TB] DEPTH+1 pushes with stalled VPU");
    vpuAuto = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(32'h1100_0001 + (i << 4));
    checkOutput("in_ready when full", in_ready, 1'b0);
    vpuAuto = 1'b1;
    strayDone = 1'b1; step(1); strayDone = 1'b0;
    waitRetired(16'd8, "stalled batch retired");
    checkOutput("model retired 8", mRetired, 16'd8);

    $display("[TB] HALT then resume");
    applyStimulus(32'h1200_0041);
    applyStimulus(32'h0000_000F);
    applyStimulus(32'h0000_0222);
    begin
      int n = 0;
      while (halted !== 1'b1 && n < 40) begin step(1); n++; end
      if (halted !== 1'b1) reportTimeout("halted reached");
    end
    checkOutput("retired at halt", retired, 16'd9);
    step(4);
    checkOutput("halted holds", halted, 1'b1);
    checkOutput("SUB not issued", busy, 1'b0);
    resume = 1'b1; step(1); resume = 1'b0;
    waitRetired(16'd10, "SUB retired");
    checkOutput("model retired 10", mRetired, 16'd10);

    $display("[TB] flush during first WAIT");
    applyStimulus(32'h0000_0101);
    applyStimulus(32'h0000_0202);
    applyStimulus(32'h0000_0303);
    flush = 1'b1; step(1); flush = 1'b0;
    waitRetired(16'd11, "first of flushed batch");
    step(8);
    checkOutput("retired after flush", retired, 16'd11);
    checkOutput("idle after flush", busy, 1'b0);
    checkOutput("model queue empty", mQueue.size(), 0);

    $display("[TB] watchdog timeout");
    vpuAuto = 1'b0;
    applyStimulus(32'h5A00_0003);
    waitStart("timeout start");
    checkOutput("issued inst", vpu_inst, 32'h5A00_0003);
    step(TIMEOUT);
    checkOutput("err before timeout", err, 1'b0);
    step(1);
    checkOutput("err at timeout", err, 1'b1);
    checkOutput("in_ready in ERR", in_ready, 1'b0);
    checkOutput("enables in ERR", vpu_read_en, 1'b0);
    rst_n = 1'b0; step(1);
    checkResetOutputs("err reset");
    rst_n = 1'b1; step(1);

    $display("[TB] reset mid-WAIT then stray done");
    applyStimulus(32'h0000_0041);
    waitStart("midwait start");
    step(2);
    checkOutput("in WAIT before reset", busy, 1'b1);
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    strayDone = 1'b1; step(1); strayDone = 1'b0;
    step(2);
    checkResetOutputs("post reset");

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
